// File: rtl/ps2_decoder_if.sv
// rtl/ps2_decoder_if.sv - PS/2 pin and decoded-key bundle for ps2_decoder
interface ps2_decoder_if;
   logic       ps2_clk_async;
   logic       ps2_data_async;
   logic [7:0] scan_code;
   logic [7:0] ascii_code;
   logic       key_pressed;
   logic       key_released;

   modport master (
      output ps2_clk_async,
      output ps2_data_async,
      input  scan_code,
      input  ascii_code,
      input  key_pressed,
      input  key_released
   );

   modport slave (
      input  ps2_clk_async,
      input  ps2_data_async,
      output scan_code,
      output ascii_code,
      output key_pressed,
      output key_released
   );
endinterface

// File: rtl/ps2_decoder.sv
// rtl/ps2_decoder.sv - PS/2 keyboard receiver and scan-code set 2 to ASCII translator
module ps2_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic          clk,
   input  logic          reset_n,
   ps2_decoder_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state, state_nxt;
   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          fall;
   logic          ps2_bit;
   logic [TW-1:0] to_cnt;
   logic          timeout;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic          byte_valid;
   logic          shift_en;
   logic          ext, brk;
   logic          lshift, rshift;

   // [0],[1] are the synchroniser stages, [2] holds the previous synced value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], bus.ps2_clk_async};
         data_sync <= {data_sync[0], bus.ps2_data_async};
      end
   end

   assign fall    = clk_sync[2] & ~clk_sync[1];
   assign ps2_bit = data_sync[1];
   assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         to_cnt <= '0;
      else if (fall || timeout || state == IDLE)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout) begin
         state_nxt = IDLE;
      end else if (fall) begin
         case (state)
            IDLE:    if (!ps2_bit) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      shift_en   = 1'b0;
      byte_valid = 1'b0;
      if (fall && !timeout) begin
         shift_en   = (state == DATA);
         byte_valid = (state == STOP) && ps2_bit && (^{shift_reg, parity_bit});
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
      end else if (fall && !timeout) begin
         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            shift_reg <= {ps2_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end else if (state == PARITY) begin
            parity_bit <= ps2_bit;
         end
      end
   end

   // Each entry packs {unshifted, shifted} characters
   function automatic logic [7:0] translate(input logic [7:0] code,
                                            input logic       shift,
                                            input logic       extended);
      logic [15:0] pair;
      pair = 16'h0000;
      case (code)
         8'h1C: pair = "aA";
         8'h32: pair = "bB";
         8'h21: pair = "cC";
         8'h23: pair = "dD";
         8'h24: pair = "eE";
         8'h2B: pair = "fF";
         8'h34: pair = "gG";
         8'h33: pair = "hH";
         8'h43: pair = "iI";
         8'h3B: pair = "jJ";
         8'h42: pair = "kK";
         8'h4B: pair = "lL";
         8'h3A: pair = "mM";
         8'h31: pair = "nN";
         8'h44: pair = "oO";
         8'h4D: pair = "pP";
         8'h15: pair = "qQ";
         8'h2D: pair = "rR";
         8'h1B: pair = "sS";
         8'h2C: pair = "tT";
         8'h3C: pair = "uU";
         8'h2A: pair = "vV";
         8'h1D: pair = "wW";
         8'h22: pair = "xX";
         8'h35: pair = "yY";
         8'h1A: pair = "zZ";
         8'h16: pair = "1!";
         8'h1E: pair = "2@";
         8'h26: pair = "3#";
         8'h25: pair = "4$";
         8'h2E: pair = "5%";
         8'h36: pair = "6^";
         8'h3D: pair = "7&";
         8'h3E: pair = "8*";
         8'h46: pair = "9(";
         8'h45: pair = "0)";
         8'h4E: pair = "-_";
         8'h55: pair = "=+";
         8'h54: pair = "[{";
         8'h5B: pair = "]}";
         8'h5D: pair = "\\|";
         8'h4C: pair = ";:";
         8'h52: pair = "'\"";
         8'h41: pair = ",<";
         8'h49: pair = ".>";
         8'h4A: pair = "/?";
         8'h0E: pair = "`~";
         8'h29: pair = 16'h2020;
         8'h5A: pair = 16'h0D0D;
         8'h66: pair = 16'h0808;
         8'h0D: pair = 16'h0909;
         8'h76: pair = 16'h1B1B;
         default: pair = 16'h0000;
      endcase
      if (extended)
         return 8'h00;
      else if (shift)
         return pair[7:0];
      else
         return pair[15:8];
   endfunction

   // Prefix flags survive timeouts and only clear when a non-prefix byte lands
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.scan_code    <= '0;
         bus.ascii_code   <= '0;
         bus.key_pressed  <= 1'b0;
         bus.key_released <= 1'b0;
         ext              <= 1'b0;
         brk              <= 1'b0;
         lshift           <= 1'b0;
         rshift           <= 1'b0;
      end else begin
         bus.key_pressed  <= 1'b0;
         bus.key_released <= 1'b0;
         if (byte_valid) begin
            if (shift_reg == 8'hE0) begin
               ext <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
               brk <= 1'b1;
            end else if (brk) begin
               bus.scan_code    <= shift_reg;
               bus.key_released <= 1'b1;
               if (!ext && shift_reg == 8'h12) lshift <= 1'b0;
               if (!ext && shift_reg == 8'h59) rshift <= 1'b0;
               brk <= 1'b0;
               ext <= 1'b0;
            end else begin
               bus.scan_code   <= shift_reg;
               bus.ascii_code  <= translate(shift_reg, lshift | rshift, ext);
               bus.key_pressed <= 1'b1;
               if (!ext && shift_reg == 8'h12) lshift <= 1'b1;
               if (!ext && shift_reg == 8'h59) rshift <= 1'b1;
               ext <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_decoder.sv
// tb/tb_ps2_decoder.sv - self-checking bench for ps2_decoder
module tb_ps2_decoder;

   localparam int TO   = 100;
   localparam int HALF = 10;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #10 clk = ~clk;

   ps2_decoder_if bus();

   ps2_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0] code;
      logic       ev;
      logic       rel;
      logic [7:0] scan;
      logic [7:0] ascii;
   } vec_t;

   typedef struct {
      logic       rel;
      logic [7:0] scan;
      logic [7:0] ascii;
   } exp_t;

   exp_t       exp_q[$];
   vec_t       tbl[24];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       prev_strobe = 1'b0;
   logic [7:0] last_scan  = 8'h00;
   logic [7:0] last_ascii = 8'h00;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, req);
      end
   endtask

   task automatic sample();
      logic strobe;
      exp_t e;
      strobe = bus.key_pressed | bus.key_released;
      if (strobe) begin
         check("strobes_exclusive", {7'd0, bus.key_pressed & bus.key_released}, 8'd0);
         check("strobe_width", {7'd0, prev_strobe}, 8'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got scan %02h pressed %0b released %0b expected none",
                     bus.scan_code, bus.key_pressed, bus.key_released);
         end else begin
            e = exp_q.pop_front();
            check("key_released", {7'd0, bus.key_released}, {7'd0, e.rel});
            check("key_pressed", {7'd0, bus.key_pressed}, {7'd0, ~e.rel});
            check("strobe_scan", bus.scan_code, e.scan);
            check("strobe_ascii", bus.ascii_code, e.ascii);
         end
      end
      prev_strobe = strobe;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         sample();
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data_async = f[i];
         tick(HALF);
         bus.ps2_clk_async = 1'b0;
         tick(HALF);
         bus.ps2_clk_async = 1'b1;
      end
      tick(HALF);
   endtask

   task automatic expect_key(input logic rel, input logic [7:0] scan, input logic [7:0] ascii);
      exp_t e;
      e.rel   = rel;
      e.scan  = scan;
      e.ascii = ascii;
      exp_q.push_back(e);
      last_scan = scan;
      if (!rel) last_ascii = ascii;
   endtask

   task automatic check_drained(input string name);
      check(name, 8'(exp_q.size()), 8'd0);
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_scan"}, bus.scan_code, last_scan);
      check({tag, "_ascii"}, bus.ascii_code, last_ascii);
   endtask

   initial begin
      bus.ps2_clk_async  = 1'b1;
      bus.ps2_data_async = 1'b1;

      tbl[0]  = '{8'h1C, 1'b1, 1'b0, 8'h1C, 8'h61};
      tbl[1]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[2]  = '{8'h1C, 1'b1, 1'b1, 8'h1C, 8'h61};
      tbl[3]  = '{8'h12, 1'b1, 1'b0, 8'h12, 8'h00};
      tbl[4]  = '{8'h1C, 1'b1, 1'b0, 8'h1C, 8'h41};
      tbl[5]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[6]  = '{8'h12, 1'b1, 1'b1, 8'h12, 8'h41};
      tbl[7]  = '{8'h1C, 1'b1, 1'b0, 8'h1C, 8'h61};
      tbl[8]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[9]  = '{8'h75, 1'b1, 1'b0, 8'h75, 8'h00};
      tbl[10] = '{8'h29, 1'b1, 1'b0, 8'h29, 8'h20};
      tbl[11] = '{8'h59, 1'b1, 1'b0, 8'h59, 8'h00};
      tbl[12] = '{8'h16, 1'b1, 1'b0, 8'h16, 8'h21};
      tbl[13] = '{8'h4E, 1'b1, 1'b0, 8'h4E, 8'h5F};
      tbl[14] = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[15] = '{8'h59, 1'b1, 1'b1, 8'h59, 8'h5F};
      tbl[16] = '{8'hE0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[17] = '{8'h12, 1'b1, 1'b0, 8'h12, 8'h00};
      tbl[18] = '{8'h1A, 1'b1, 1'b0, 8'h1A, 8'h7A};
      tbl[19] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 8'h0D};
      tbl[20] = '{8'hE0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[21] = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[22] = '{8'h12, 1'b1, 1'b1, 8'h12, 8'h0D};
      tbl[23] = '{8'h5D, 1'b1, 1'b0, 8'h5D, 8'h5C};

      tick(5);
      check("reset_scan", bus.scan_code, 8'h00);
      check("reset_ascii", bus.ascii_code, 8'h00);
      check("reset_pressed", {7'd0, bus.key_pressed}, 8'd0);
      check("reset_released", {7'd0, bus.key_released}, 8'd0);
      reset_n = 1'b1;
      tick(5);

      for (int i = 0; i < 24; i++) begin
         if (tbl[i].ev) expect_key(tbl[i].rel, tbl[i].scan, tbl[i].ascii);
         send_frame(tbl[i].code, 1'b0, 1'b0, 11);
         check_drained("missed_strobe");
         check_outputs("table");
      end

      send_frame(8'h1C, 1'b1, 1'b0, 11);
      check_outputs("bad_parity");
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check_outputs("bad_stop");

      send_frame(8'h1C, 1'b0, 1'b0, 5);
      tick(TO + 50);
      check_outputs("stalled");
      expect_key(1'b0, 8'h16, 8'h31);
      send_frame(8'h16, 1'b0, 1'b0, 11);
      check_drained("after_timeout");

      send_frame(8'hE0, 1'b0, 1'b0, 11);
      send_frame(8'h29, 1'b0, 1'b0, 4);
      tick(TO + 50);
      expect_key(1'b0, 8'h1C, 8'h00);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check_drained("ext_across_timeout");

      send_frame(8'hE0, 1'b0, 1'b0, 11);
      send_frame(8'h29, 1'b0, 1'b0, 6);
      reset_n = 1'b0;
      tick(3);
      check("midreset_scan", bus.scan_code, 8'h00);
      check("midreset_ascii", bus.ascii_code, 8'h00);
      check("midreset_pressed", {7'd0, bus.key_pressed}, 8'd0);
      check("midreset_released", {7'd0, bus.key_released}, 8'd0);
      reset_n = 1'b1;
      tick(5);
      expect_key(1'b0, 8'h1C, 8'h61);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check_drained("after_reset");
      check_outputs("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
